// File: rtl/lc3b_types.sv
// Shared LC-3b types: the 16-bit data word and the memory responder state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lc3b_memstate;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with independent byte-lane writes and a combinational read port.
module mem_array
    import lc3b_types::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  lc3b_word      wdata,
    output lc3b_word      rdata
);

    lc3b_word mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem_q[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem_q[addr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, answers LATENCY cycles later.
// Optional MEM_RESPONDER_ERR_EN adds mem_err for read+write collisions and out-of-range addresses.
module mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  lc3b_word    mem_wdata,
    output lc3b_word    mem_rdata,
    output logic        mem_resp
`ifdef MEM_RESPONDER_ERR_EN
    ,
    output logic        mem_err
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    lc3b_memstate  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          is_read_q, is_read_d;
    logic          is_write_q, is_write_d;
    logic [1:0]    be_q, be_d;
    logic [AW-1:0] idx_q, idx_d;
    lc3b_word      wdata_q, wdata_d;
    logic          resp_q, resp_d;
    lc3b_word      rdata_q, rdata_d;
    lc3b_word      arr_rdata;
    logic          arr_we;
    logic          unused_addr;

    assign unused_addr = ^mem_address;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_read_d  = is_read_q;
        is_write_d = is_write_q;
        be_d       = be_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    is_read_d  = mem_read;
                    // A simultaneous read and write resolves to a read only.
                    is_write_d = mem_write && !mem_read;
                    be_d       = mem_byte_enable;
                    idx_d      = mem_address[AW:1];
                    wdata_d    = mem_wdata;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data is captured on entry to DONE; storage only changes at the end of DONE.
    always_comb begin
        resp_d  = (state_d == DONE);
        rdata_d = (state_d == DONE && is_read_d) ? arr_rdata : 16'h0000;
    end

    assign arr_we = (state_q == DONE) && is_write_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        is_read_q  <= is_read_d;
        is_write_q <= is_write_d;
        be_q       <= be_d;
        idx_q      <= idx_d;
        wdata_q    <= wdata_d;
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be_q),
        .addr  (idx_d),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;

`ifdef MEM_RESPONDER_ERR_EN
    logic err_flag_q, err_flag_d;
    logic err_q, err_d;

    always_comb begin
        err_flag_d = err_flag_q;
        if (state_q == IDLE && (mem_read || mem_write))
            err_flag_d = (mem_read && mem_write) ||
                         ({1'b0, mem_address[15:1]} >= 16'(DEPTH_WORDS));
        err_d = (state_d == DONE) && err_flag_d;
    end

    always_ff @(posedge clk) begin
        err_flag_q <= err_flag_d;
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign mem_err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LATENCY=4, DEPTH_WORDS=256) against an array reference model.
module tb_mem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
`ifdef MEM_RESPONDER_ERR_EN
    logic        mem_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_resp_cyc = 0;
    logic [15:0] model [DEPTH];

    mem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
`ifdef MEM_RESPONDER_ERR_EN
        ,
        .mem_err         (mem_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    endfunction

    // One complete transaction: drive in an IDLE cycle, scramble inputs while busy,
    // check the response window cycle by cycle, then update the model.
    task automatic req(input bit rd, input bit wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input bit hold_rd, input string tag, output logic [15:0] got);
        int          idx;
        logic [15:0] exp_rd;
        bit          exp_err;
        idx     = int'(addr[8:1]);
        exp_rd  = rd ? model[idx] : 16'h0000;
        exp_err = (rd && wr) || (addr[15:9] != 7'd0);
        got     = 16'h0000;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_byte_enable = be;
        mem_address = addr; mem_wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            check({tag, "_resp"}, 32'(mem_resp), 32'(c == LAT));
            if (c == LAT) begin
                got = mem_rdata;
                check({tag, "_rdata"}, 32'(mem_rdata), 32'(exp_rd));
`ifdef MEM_RESPONDER_ERR_EN
                check({tag, "_err"}, 32'(mem_err), 32'(exp_err));
`endif
                last_resp_cyc = cyc;
                mem_read = hold_rd; mem_write = 1'b0;
            end else begin
                check({tag, "_rdata_idle"}, 32'(mem_rdata), 32'h0);
                mem_read = 1'($urandom); mem_write = 1'($urandom);
                mem_byte_enable = 2'($urandom); mem_address = 16'($urandom);
                mem_wdata = 16'($urandom);
            end
        end
        if (wr && !rd) model[idx] = merge(model[idx], wd, be);
        if (exp_err && !rd) got = got; // collision flag only matters with the ERR build
    endtask

    initial begin
        logic [15:0] got;
        int r1;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        mem_address = 16'h0000; mem_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_resp", 32'(mem_resp), 32'h0);
        check("reset_rdata", 32'(mem_rdata), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_resp", 32'(mem_resp), 32'h0);

        // Fill every word so later reads have defined contents.
        for (int i = 0; i < DEPTH; i++)
            req(1'b0, 1'b1, 2'b11, 16'(i * 2), 16'($urandom), 1'b0, "init", got);

        req(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0, "wr_beef", got);
        req(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, "rd_beef", got);
        check("beef_value", 32'(got), 32'h0000BEEF);

        req(1'b0, 1'b1, 2'b01, 16'h0010, 16'h1234, 1'b0, "wr_lane0", got);
        req(1'b1, 1'b0, 2'b00, 16'h0011, 16'h0000, 1'b0, "rd_lane0", got);
        check("be34_value", 32'(got), 32'h0000BE34);

        req(1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, 1'b0, "wr_be00", got);
        req(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b1, "rd_be00", got);
        check("be00_value", 32'(got), 32'h0000BE34);
        r1 = last_resp_cyc;
        req(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, "b2b", got);
        check("b2b_spacing", 32'(last_resp_cyc - r1), 32'(LAT + 1));

        req(1'b0, 1'b1, 2'b11, 16'h0010, 16'hA5A5, 1'b0, "wr_a5", got);
        req(1'b1, 1'b0, 2'b00, 16'h0210, 16'h0000, 1'b0, "rd_wrap", got);
        check("wrap_value", 32'(got), 32'h0000A5A5);

        req(1'b1, 1'b1, 2'b11, 16'h0010, 16'h0000, 1'b0, "rd_wr_both", got);
        check("both_value", 32'(got), 32'h0000A5A5);
        req(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, "rd_after_both", got);
        check("both_unchanged", 32'(got), 32'h0000A5A5);

        // Reset two cycles into a write must abort it silently.
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; mem_byte_enable = 2'b11;
        mem_address = 16'h0010; mem_wdata = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        check("abort_resp_c1", 32'(mem_resp), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check("abort_resp_c2", 32'(mem_resp), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_quiet_resp", 32'(mem_resp), 32'h0);
            check("abort_quiet_rdata", 32'(mem_rdata), 32'h0);
        end
        req(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0, "rd_after_abort", got);
        check("abort_unchanged", 32'(got), 32'h0000A5A5);

        for (int i = 0; i < 80; i++) begin
            logic [1:0] op;
            op = 2'($urandom);
            req(op[0] | (op == 2'b00), op[1], 2'($urandom), 16'($urandom),
                16'($urandom), 1'($urandom), "rand", got);
        end

        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(negedge clk);
        check("final_idle_resp", 32'(mem_resp), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256: number of 16-bit storage words; power of two, 2..32768.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_read  input  1  read request from the datapath/control side.
REQ-006 SHALL have port mem_write  input  1  write request.
REQ-007 SHALL have port mem_byte_enable  input  2  write byte lanes; bit 1 is [15:8], bit 0 is [7:0].
REQ-008 SHALL have port mem_address  input  16  byte address; bit 0 ignored.
REQ-009 SHALL have port mem_wdata  input  16  write data.
REQ-010 SHALL have port mem_rdata  output  16  read data; valid only while mem_resp is high.
REQ-011 SHALL have port mem_resp  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, WAIT, DONE.
REQ-013 In IDLE with mem_read or mem_write high, SHALL accept the request and latch address, wdata, byte enables and operation.
REQ-014 If LATENCY=1, SHALL go IDLE->DONE; otherwise SHALL go IDLE->WAIT, load counter with LATENCY-2 and decrement each cycle, moving to DONE when the counter is 0.
REQ-015 Request accepted at edge N SHALL produce mem_resp high during exactly cycle N+LATENCY, then return to IDLE.
REQ-016 Read: mem_rdata SHALL equal the stored word at the latched address during the DONE cycle; otherwise mem_rdata SHALL be 0.
REQ-017 Write: SHALL update only the enabled byte lanes at the clock edge ending DONE; byte_enable 2'b00 SHALL complete with mem_resp and leave storage unchanged.
REQ-018 When mem_read and mem_write are both high at acceptance, SHALL treat the request as a read and perform no write.
REQ-019 Word index SHALL be mem_address[15:1] modulo DEPTH_WORDS; higher bits wrap.
REQ-020 Input changes after acceptance, including a deassertion, SHALL be ignored; the latched operation completes and mem_resp still pulses.
REQ-021 In the cycle after mem_resp, the responder SHALL be in IDLE and SHALL accept a request still asserted there as a new request (back-to-back).
REQ-022 A write followed by a read of the same word SHALL return the written data.

Reset
REQ-023 On rst high at a clock edge, SHALL enter IDLE, clear the counter and drive mem_resp=0 and mem_rdata=0 from the next cycle.
REQ-024 Reset during WAIT or DONE SHALL abort the operation with no write and no mem_resp.
REQ-025 Storage contents SHALL NOT be reset.

Configuration
REQ-026 With MEM_RESPONDER_ERR_EN defined, SHALL add output mem_err (1 bit), high only with mem_resp, when the accepted request had both read and write high or mem_address[15:1] >= DEPTH_WORDS.
REQ-027 Without MEM_RESPONDER_ERR_EN, port mem_err and its logic SHALL be absent and behaviour otherwise SHALL be identical.

Structure
REQ-028 lc3b_types SHALL supply lc3b_word and SHALL gain the state enum lc3b_memstate (IDLE, WAIT, DONE).
REQ-029 Storage SHALL be the sub-module mem_array: synchronous byte-lane write, combinational read, DEPTH_WORDS parameter.
REQ-030 FSM, counter and request latches SHALL reside in mem_responder.

Verification (LATENCY=4, DEPTH_WORDS=256)
REQ-031 Write 16'hBEEF to 0x0010 with be=2'b11, then read 0x0010 -> mem_resp 4 cycles after each acceptance; mem_rdata=16'hBEEF.
REQ-032 Word is 16'hBEEF; write 16'h1234 with be=2'b01, then read -> mem_rdata=16'hBE34.
REQ-033 Read held high through mem_resp -> second acceptance in the cycle after mem_resp; second mem_resp 4 cycles later; no idle gap.
REQ-034 Read 0x0210 after writing 16'hA5A5 to 0x0010 -> wrap returns 16'hA5A5; with ERR_EN, mem_err=1 on that mem_resp.
REQ-035 rst pulsed 2 cycles after a write acceptance -> no mem_resp, stored word unchanged, next request completes after 4 cycles.
REQ-036 mem_read and mem_write both high with wdata 16'h0000 -> read completes, storage unchanged; with ERR_EN, mem_err=1.
